// File: rtl/map_rst_vec_det.sv
// Console reset detector: watches the CPU bus for the 6502 reset sequence
// (three stack reads, then $FFFC/$FFFD) and produces a held sys_rst level,
// a one-clock detection strobe and a wrapping detection count.
module map_rst_vec_det #(
    parameter int unsigned HOLD_M2 = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              map_rst,
    input  logic              m2,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rw,
    input  logic              det_en,
    output logic              sys_rst,
    output logic              rst_evt,
    output logic [CNT_W-1:0]  rst_cnt
);

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned HOLD_W = $clog2(HOLD_M2 + 1);

    localparam logic [7:0]        STACK_PAGE = 8'h01;
    localparam logic [ADDR_W-1:0] VEC_LO     = 16'hFFFC;
    localparam logic [ADDR_W-1:0] VEC_HI     = 16'hFFFD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_S1   = 3'd1,
        ST_S2   = 3'd2,
        ST_S3   = 3'd3,
        ST_VEC  = 3'd4
    } state_t;

    // M2 synchronizer and edge history
    logic m2_meta;
    logic m2_s;
    logic m2_s_d;

    // Bus cycle captured while M2 is high
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_rw;

    // FSM and hold state
    state_t            state;
    state_t            state_n;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_n;
    logic              sys_rst_n;
    logic              rst_evt_n;
    logic [CNT_W-1:0]  rst_cnt_n;

    // Internal combinational decode
    logic fall_c;
    logic stk_rd_c;
    logic stk_wr_c;
    logic vlo_c;
    logic vhi_c;
    logic det_c;

    // Bring M2 into the clk domain and keep one clock of history
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            m2_meta <= 1'b0;
            m2_s    <= 1'b0;
            m2_s_d  <= 1'b0;
        end else begin
            m2_meta <= m2;
            m2_s    <= m2_meta;
            m2_s_d  <= m2_s;
        end
    end

    // Track the bus while M2 is high; values hold through the fall event
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            cap_addr <= '0;
            cap_rw   <= 1'b0;
        end else if (m2_s) begin
            cap_addr <= cpu_addr;
            cap_rw   <= cpu_rw;
        end
    end

    // Classify the just-completed bus cycle
    always_comb begin
        fall_c   = m2_s_d & ~m2_s;
        stk_rd_c = cap_rw & (cap_addr[15:8] == STACK_PAGE);
        stk_wr_c = ~cap_rw & (cap_addr[15:8] == STACK_PAGE);
        vlo_c    = cap_rw & (cap_addr == VEC_LO);
        vhi_c    = cap_rw & (cap_addr == VEC_HI);
    end

    // State and output registers
    always_ff @(posedge clk or posedge map_rst) begin
        if (map_rst) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            sys_rst  <= 1'b0;
            rst_evt  <= 1'b0;
            rst_cnt  <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            sys_rst  <= sys_rst_n;
            rst_evt  <= rst_evt_n;
            rst_cnt  <= rst_cnt_n;
        end
    end

    // Sequence tracking, detection, hold countdown
    always_comb begin
        state_n    = state;
        det_c      = 1'b0;
        hold_cnt_n = hold_cnt;
        sys_rst_n  = sys_rst;
        rst_evt_n  = 1'b0;
        rst_cnt_n  = rst_cnt;

        if (!det_en) begin
            state_n = ST_IDLE;
        end else if (fall_c) begin
            // Pushes to the stack mean NMI/IRQ/BRK, never a reset
            if (stk_wr_c) begin
                state_n = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state_n = stk_rd_c ? ST_S1 : ST_IDLE;
                    ST_S1:   state_n = stk_rd_c ? ST_S2 : ST_IDLE;
                    ST_S2:   state_n = stk_rd_c ? ST_S3 : ST_IDLE;
                    ST_S3: begin
                        if (vlo_c)
                            state_n = ST_VEC;
                        else if (stk_rd_c)
                            state_n = ST_S3;
                        else
                            state_n = ST_IDLE;
                    end
                    ST_VEC: begin
                        if (vhi_c) begin
                            det_c   = 1'b1;
                            state_n = ST_IDLE;
                        end else if (stk_rd_c) begin
                            state_n = ST_S1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end

        // A detection reloads the hold; it takes priority over the countdown
        if (det_c) begin
            hold_cnt_n = HOLD_W'(HOLD_M2);
            sys_rst_n  = 1'b1;
            rst_evt_n  = 1'b1;
            rst_cnt_n  = rst_cnt + CNT_W'(1);
        end else if (fall_c && (hold_cnt != '0)) begin
            hold_cnt_n = hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1))
                sys_rst_n = 1'b0;
        end
    end

endmodule
